// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, frame defaults and the
// baud-divisor helper used by both the transmitter and the receiver.
package uart_tx_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int SB_TICK_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } tx_state_e;

    // Clocks per baud tick; clamped so a too-fast baud still yields a legal divider.
    function automatic int calc_dvsr(input int clk_freq, input int baud_rate, input int sb_tick);
        int dvsr;
        dvsr = clk_freq / (baud_rate * sb_tick);
        if (dvsr < 1) begin
            dvsr = 1;
        end else begin
            dvsr = dvsr;
        end
        return dvsr;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level handshake between the debug unit (master) and the UART transmitter (slave).
interface uart_tx_if
    import uart_tx_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF
);
    logic               tx_start;
    logic [NB_DATA-1:0] tx_data;
    logic               tx;
    logic               tx_done;
    logic               tx_busy;

    modport master (
        output tx_start,
        output tx_data,
        input  tx,
        input  tx_done,
        input  tx_busy
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx,
        output tx_done,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx_baud_gen.sv
// Baud tick generator: one-clock tick every DVSR clocks, restartable so that
// a new frame always begins on a full tick period.
module uart_tx_baud_gen #(
    parameter int DVSR = 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);
    localparam int            CW   = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next divider count: wrap at LAST or restart on clear.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == LAST);
endmodule

// File: rtl/uart_tx.sv
// 8N1 LSB-first UART transmitter with a post-frame guard gap so the producer
// has time to update its data after seeing the done pulse.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int NB_DATA    = NB_DATA_DEF,
    parameter int SB_TICK    = SB_TICK_DEF,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 19200,
    parameter int GAP_CYCLES = 2
) (
    input  logic     i_clock,
    input  logic     i_reset,
    uart_tx_if.slave bus
);
    localparam int DVSR = calc_dvsr(CLK_FREQ, BAUD_RATE, SB_TICK);
    localparam int SW   = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
    localparam int NW   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [SW-1:0] S_LAST   = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST   = NW'(NB_DATA - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    tx_state_e          state_q, state_d;
    logic [NB_DATA-1:0] shreg_q, shreg_d;
    logic [SW-1:0]      s_q, s_d;
    logic [NW-1:0]      n_q, n_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               accept_s;
    logic               tick_s;

    assign accept_s = (state_q == ST_IDLE) && bus.tx_start;

    uart_tx_baud_gen #(
        .DVSR (DVSR)
    ) u_baud (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (accept_s),
        .o_tick  (tick_s)
    );

    // Next-state and datapath logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        s_d     = s_q;
        n_d     = n_q;
        gap_d   = gap_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.tx_start) begin
                    shreg_d = bus.tx_data;
                    s_d     = '0;
                    n_d     = '0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        shreg_d = {1'b0, shreg_q[NB_DATA-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        gap_d   = '0;
                        done_d  = 1'b1;
                        state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // FSM, datapath and output registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            s_q     <= '0;
            n_q     <= '0;
            gap_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            s_q     <= s_d;
            n_q     <= n_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_done = done_q;
    assign bus.tx_busy = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table vectors, corner-case sequences and
// random frames against a frame-level line model (DVSR=1, 16 clocks per bit).
module tb_uart_tx;
    localparam int BIT_CLK   = 16;
    localparam int FRAME_CLK = 10 * BIT_CLK;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    uart_tx_if #(.NB_DATA(8)) bus ();

    uart_tx #(
        .NB_DATA    (8),
        .SB_TICK    (16),
        .CLK_FREQ   (160),
        .BAUD_RATE  (10),
        .GAP_CYCLES (2)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a frame from IDLE and checks every clock up to and including the done cycle.
    task automatic run_frame(input logic [7:0] d, input logic keep, input logic [7:0] later,
                             output logic [9:0] seen);
        logic [9:0] frame;
        logic       exp_tx;
        frame = {1'b1, d, 1'b0};
        seen  = '0;
        bus.tx_start = 1'b1;
        bus.tx_data  = d;
        tick();
        bus.tx_start = keep;
        bus.tx_data  = later;
        for (int c = 0; c <= FRAME_CLK; c++) begin
            exp_tx = (c < FRAME_CLK) ? frame[c / BIT_CLK] : 1'b1;
            chk($sformatf("tx@%0d", c), 32'(bus.tx), 32'(exp_tx));
            chk($sformatf("done@%0d", c), 32'(bus.tx_done), 32'(c == FRAME_CLK));
            chk($sformatf("busy@%0d", c), 32'(bus.tx_busy), 32'(1'b1));
            if ((c % BIT_CLK) == 8) seen[c / BIT_CLK] = bus.tx;
            if (c < FRAME_CLK) tick();
        end
    endtask

    // The two guard clocks after the done cycle: line high, no done, busy drops on return to IDLE.
    task automatic do_gap();
        tick();
        chk("gap1_tx", 32'(bus.tx), 32'(1'b1));
        chk("gap1_done", 32'(bus.tx_done), 32'(1'b0));
        chk("gap1_busy", 32'(bus.tx_busy), 32'(1'b1));
        tick();
        chk("gap2_tx", 32'(bus.tx), 32'(1'b1));
        chk("gap2_done", 32'(bus.tx_done), 32'(1'b0));
        chk("gap2_busy", 32'(bus.tx_busy), 32'(1'b0));
    endtask

    initial begin
        logic [9:0] seen;
        logic [7:0] d;
        logic       keep;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;

        tbl[0] = '{8'hA5, 10'b1101001010};
        tbl[1] = '{8'h00, 10'b1000000000};
        tbl[2] = '{8'hFF, 10'b1111111110};
        tbl[3] = '{8'h3C, 10'b1001111000};
        tbl[4] = '{8'h01, 10'b1000000010};
        tbl[5] = '{8'h80, 10'b1100000000};

        repeat (3) tick();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_tx", 32'(bus.tx), 32'(1'b1));
            chk("idle_done", 32'(bus.tx_done), 32'(1'b0));
            chk("idle_busy", 32'(bus.tx_busy), 32'(1'b0));
        end

        foreach (tbl[i]) begin
            run_frame(tbl[i].data, 1'b0, ~tbl[i].data, seen);
            chk($sformatf("line_%02h", tbl[i].data), 32'(seen), 32'(tbl[i].line));
            do_gap();
        end

        // Start held through frame 1 while data changes; frame 2 follows after the guard.
        run_frame(8'h00, 1'b1, 8'hFF, seen);
        chk("held_f1", 32'(seen), 32'(10'b1000000000));
        do_gap();
        run_frame(8'hFF, 1'b0, 8'h00, seen);
        chk("held_f2", 32'(seen), 32'(10'b1111111110));
        do_gap();

        // Start raised in the done cycle must wait for IDLE.
        run_frame(8'h5A, 1'b0, 8'h00, seen);
        chk("pre_gap", 32'(seen), 32'(10'b1010110100));
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'hC3;
        do_gap();
        run_frame(8'hC3, 1'b0, 8'h00, seen);
        chk("gap_start", 32'(seen), 32'(10'b1110000110));
        do_gap();

        // Reset in the middle of data bit 4.
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'hC3;
        tick();
        bus.tx_start = 1'b0;
        repeat (88) tick();
        chk("mid_bit4", 32'(bus.tx), 32'(1'b0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_tx", 32'(bus.tx), 32'(1'b1));
        chk("rst_busy", 32'(bus.tx_busy), 32'(1'b0));
        chk("rst_done", 32'(bus.tx_done), 32'(1'b0));
        for (int i = 0; i < 200; i++) begin
            tick();
            chk("post_rst_tx", 32'(bus.tx), 32'(1'b1));
            chk("post_rst_done", 32'(bus.tx_done), 32'(1'b0));
            chk("post_rst_busy", 32'(bus.tx_busy), 32'(1'b0));
        end
        run_frame(8'h96, 1'b0, 8'h00, seen);
        chk("after_rst", 32'(seen), 32'(10'b1100101100));
        do_gap();

        // Random bytes, random hold, random idle spacing.
        for (int i = 0; i < 12; i++) begin
            d    = 8'($urandom);
            keep = 1'($urandom_range(0, 1));
            run_frame(d, keep, 8'($urandom), seen);
            chk($sformatf("rand_%0d", i), 32'(seen), 32'({1'b1, d, 1'b0}));
            do_gap();
            if (!keep) begin
                for (int k = 0; k < int'($urandom_range(0, 5)); k++) begin
                    tick();
                    chk("rand_idle_tx", 32'(bus.tx), 32'(1'b1));
                    chk("rand_idle_busy", 32'(bus.tx_busy), 32'(1'b0));
                end
            end
        end
        bus.tx_start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
